// File: rtl/rv_console_uart_if.sv
// Data-memory port bundle between the rv_cpu load/store unit and the console UART.
interface rv_console_uart_if;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_s_i;
    logic [3:0]  dm_data_select_i;
    logic        dm_write_i;
    logic [31:0] dm_data_l_o;
    logic        dm_valid_l_o;

    modport master (
        output dm_addr_i, dm_data_s_i, dm_data_select_i, dm_write_i,
        input  dm_data_l_o, dm_valid_l_o
    );

    modport slave (
        input  dm_addr_i, dm_data_s_i, dm_data_select_i, dm_write_i,
        output dm_data_l_o, dm_valid_l_o
    );
endinterface

// File: rtl/rv_console_uart.sv
// Console UART on the rv_cpu data-memory port: byte stores to the TX register
// are queued in a small FIFO and sent as back-to-back 8N1 frames; a status word
// is readable at base+4 with one cycle of registered load latency.
module rv_console_uart #(
    parameter logic [31:0] g_base_addr  = 32'h00100000,
    parameter int          g_clk_div    = 16,
    parameter int          g_fifo_depth = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    rv_console_uart_if.slave dm,
    output logic             txd_o,
    output logic             busy_o
);
    localparam int AW = $clog2(g_fifo_depth);
    localparam int CW = $clog2(g_clk_div);
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(g_fifo_depth);
    localparam logic [CW-1:0] DIV_LAST = CW'(g_clk_div - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    mem [g_fifo_depth];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          overflow;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] div_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    logic        full;
    logic        empty;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        ovf_clr;
    logic        status_rd;
    logic        bit_end;
    logic [8:0]  count_ext;
    logic [31:0] status;
    logic        unused_lanes;

    assign full      = (count == DEPTH);
    assign empty     = (count == '0);
    assign push_req  = dm.dm_write_i && (dm.dm_addr_i == g_base_addr) && dm.dm_data_select_i[0];
    assign push      = push_req && !full;
    assign ovf_clr   = dm.dm_write_i && (dm.dm_addr_i == g_base_addr + 32'd4);
    assign status_rd = !dm.dm_write_i && (dm.dm_addr_i == g_base_addr + 32'd4);
    assign bit_end   = (div_cnt == DIV_LAST);
    assign count_ext = 9'(count);
    assign status    = {16'h0000, count_ext[7:0], 4'h0, overflow, (state != S_IDLE), empty, full};
    assign count_nxt = count + (AW + 1)'(push) - (AW + 1)'(pop);

    // Only lane 0 of a TX store carries the byte; the rest of the store word is don't-care.
    assign unused_lanes = ^{dm.dm_data_s_i[31:8], dm.dm_data_select_i[3:1]};

    // Frame sequencing: pop from IDLE, or straight from the end of STOP so frames run back-to-back.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    state_nxt = S_START;
                    pop       = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (bit_end && (bit_idx == 3'd7)) state_nxt = S_STOP;
            end
            default: begin
                if (bit_end) begin
                    if (!empty) begin
                        state_nxt = S_START;
                        pop       = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
        endcase
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= dm.dm_data_s_i[7:0];
    end

    // FIFO pointers, occupancy and the sticky overflow flag (full judged on the pre-edge count).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            if (push_req && full) overflow <= 1'b1;
            else if (ovf_clr)     overflow <= 1'b0;
        end
    end

    // Serialiser: start bit, eight data bits LSB first, stop bit, each g_clk_div cycles wide.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            txd_o   <= 1'b1;
        end else begin
            state <= state_nxt;
            if (pop) begin
                shreg   <= mem[rd_ptr];
                div_cnt <= '0;
                txd_o   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        div_cnt <= '0;
                    end
                    S_START: begin
                        if (bit_end) begin
                            div_cnt <= '0;
                            bit_idx <= '0;
                            txd_o   <= shreg[0];
                        end else begin
                            div_cnt <= div_cnt + CW'(1);
                        end
                    end
                    S_DATA: begin
                        if (bit_end) begin
                            div_cnt <= '0;
                            if (bit_idx == 3'd7) begin
                                txd_o <= 1'b1;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                shreg   <= {1'b0, shreg[7:1]};
                                txd_o   <= shreg[1];
                            end
                        end else begin
                            div_cnt <= div_cnt + CW'(1);
                        end
                    end
                    default: begin
                        if (bit_end) div_cnt <= '0;
                        else         div_cnt <= div_cnt + CW'(1);
                    end
                endcase
            end
        end
    end

    // Registered status load and busy flag; busy tracks the post-edge FIFO/FSM state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dm.dm_data_l_o  <= '0;
            dm.dm_valid_l_o <= 1'b0;
            busy_o          <= 1'b0;
        end else begin
            busy_o <= (count_nxt != '0) || (state_nxt != S_IDLE);
            if (status_rd) begin
                dm.dm_data_l_o  <= status;
                dm.dm_valid_l_o <= 1'b1;
            end else begin
                dm.dm_data_l_o  <= '0;
                dm.dm_valid_l_o <= 1'b0;
            end
        end
    end
endmodule

// File: doc/rv_console_uart.md
Name: rv_console_uart

Overview:
Synthesizable console peripheral on the rv_cpu data-memory port. It replaces the simulation-only "TX byte to file" hook at 0x100000 with real hardware. CPU stores to the TX register are pushed into a small byte FIFO and serialised as 8N1 UART frames. A status register is readable through the same load interface, with the one-cycle registered latency the CPU already expects from data memory.

Parameters:
g_base_addr, 32'h00100000, byte address of TX data register; status register at g_base_addr+4
g_clk_div, 16, clock cycles per UART bit (>=2)
g_fifo_depth, 8, TX FIFO entries; power of two, 2..256

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, synchronous, active-high
dm_addr_i  in  32  data-memory byte address from CPU
dm_data_s_i  in  32  store data from CPU
dm_data_select_i  in  4  byte-lane enables for store
dm_write_i  in  1  store strobe, one cycle per store
dm_data_l_o  out  32  load data (registered)
dm_valid_l_o  out  1  load data valid (registered)
txd_o  out  1  UART serial output, idle high
busy_o  out  1  FIFO non-empty or frame in progress

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values (every output):
  - txd_o=1, dm_valid_l_o=0, dm_data_l_o=0, busy_o=0.
  - FIFO empty, overflow flag 0, FSM IDLE, bit counters 0.
- Address decode uses full 32-bit compare; no aliasing.
- TX push conditions:
  - dm_write_i=1, dm_addr_i==g_base_addr, dm_data_select_i[0]=1: push dm_data_s_i[7:0].
  - Lanes 1-3 and dm_data_s_i[31:8] are ignored.
  - Store with select[0]=0 to the base address: no effect.
- FIFO full:
  - Full is evaluated on the pre-edge count.
  - A push while full is dropped and sets the sticky overflow flag, even if a pop happens on the same edge.
- Overflow clear: any store to g_base_addr+4 (any lane) clears overflow.
- Simultaneous push and pop on a non-full FIFO: both occur, count unchanged.
- Status word, bit layout:
  - bit0: FIFO full.
  - bit1: FIFO empty.
  - bit2: FSM != IDLE.
  - bit3: overflow.
  - bits[15:8]: FIFO count (zero-extended); a full FIFO of 256 reads as 0 with bit0=1.
  - All other bits 0.
- Load path (evaluated every edge):
  - If dm_addr_i==g_base_addr+4 and dm_write_i=0: dm_data_l_o <= status, dm_valid_l_o <= 1.
  - Otherwise: dm_valid_l_o <= 0, dm_data_l_o <= 0.
  - Latency is exactly one cycle. Status reflects pre-edge state.
  - Reads of g_base_addr return 0 with valid=0.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop into shift register, go to START, and drive txd_o=0 from this edge.
  - START: hold txd_o=0 for g_clk_div cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held g_clk_div cycles, then go to STOP.
  - STOP: hold txd_o=1 for g_clk_div cycles.
- End of STOP:
  - If FIFO non-empty, pop and go directly to START. No idle gap; frames are back-to-back.
  - Otherwise go to IDLE.
- Frame length: 10*g_clk_div cycles.
- txd_o is a register output; no combinational path from inputs.
- Push-to-start timing: a byte pushed at edge E into an empty FIFO with FSM IDLE is popped at edge E+1, and txd_o falls after edge E+1.
- busy_o (registered): 1 when FIFO non-empty or FSM != IDLE, otherwise 0.
- Reset mid-frame: on the reset edge txd_o returns to 1, the frame is truncated and FIFO contents are discarded.

Test Plan:
- Reset, then load from 0x00100004 → dm_valid_l_o=1 with dm_data_l_o=0x00000002 on the next cycle; txd_o=1.
- g_clk_div=4: store 0x55 with select=4'b0001 to 0x00100000 → txd_o low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4; busy_o drops after 40 cycles.
- Two consecutive stores 0xA5 then 0x3C → 80 contiguous frame cycles with no idle cycle between the stop bit and the second start bit; bytes decoded in order.
- 9 stores in 9 cycles with g_fifo_depth=8 → first byte popped at the 2nd edge, so 9th accepted and status shows count≤8; repeat with 10 stores → overflow bit3=1. Store to 0x00100004 → bit3 reads 0.
- Store 0x41 with select=4'b0010 to 0x00100000, and a store to 0x00100008 → no frame, FIFO empty, status 0x00000002.
- Assert rst_i for 1 cycle during the DATA bit of the 2nd of 3 queued frames → txd_o=1 next cycle, busy_o=0, status 0x00000002, no further frames.
